// File: rtl/fp_sgnj_arb.sv
// Round-robin two-port arbiter feeding a sign-injection stage and a single
// valid/ready output register. Define FP_SGNJ_NANBOX_EN to NaN-box single results.
module fp_sgnj_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_data1,
    input  logic [63:0]      req0_data2,
    input  logic [1:0]       req0_fmt,
    input  logic [2:0]       req0_rm,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_data1,
    input  logic [63:0]      req1_data2,
    input  logic [1:0]       req1_fmt,
    input  logic [2:0]       req1_rm,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_src
);

`ifdef FP_SGNJ_NANBOX_EN
    localparam logic [31:0] SINGLE_UPPER = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] SINGLE_UPPER = 32'h0000_0000;
`endif

    function automatic logic [63:0] sgnj(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] fmt, input logic [2:0] rm);
        logic       sa;
        logic       sb;
        logic       s;
        logic [63:0] r;
        sa = (fmt == 2'd1) ? a[63] : a[31];
        sb = (fmt == 2'd1) ? b[63] : b[31];
        case (rm)
            3'd0:    s = sb;
            3'd1:    s = ~sb;
            3'd2:    s = sa ^ sb;
            default: s = 1'b0;
        endcase
        case (fmt)
            2'd0:    r = {SINGLE_UPPER, s, a[30:0]};
            2'd1:    r = {s, a[62:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [63:0]      data1  [2];
    logic [63:0]      data2  [2];
    logic [1:0]       fmt    [2];
    logic [2:0]       rm     [2];
    logic [TAG_W-1:0] tag    [2];
    logic [63:0]      result [2];
    logic [1:0]       valid;
    logic [1:0]       grant;
    logic [1:0]       ready;
    logic             last_reg;
    logic             can_load;
    logic             accept;
    logic             sel;

    assign data1[0] = req0_data1;
    assign data1[1] = req1_data1;
    assign data2[0] = req0_data2;
    assign data2[1] = req1_data2;
    assign fmt[0]   = req0_fmt;
    assign fmt[1]   = req1_fmt;
    assign rm[0]    = req0_rm;
    assign rm[1]    = req1_rm;
    assign tag[0]   = req0_tag;
    assign tag[1]   = req1_tag;
    assign valid    = {req1_valid, req0_valid};

    assign can_load = !out_valid || out_ready;

    // A port wins if it is alone, or on a tie if it was not the last winner.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign grant[gi]  = valid[gi] && (!valid[1-gi] || (last_reg != gi[0]));
            assign ready[gi]  = grant[gi] && can_load && !flush;
            assign result[gi] = sgnj(data1[gi], data2[gi], fmt[gi], rm[gi]);
        end
    endgenerate

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign accept     = |(ready & valid);
    assign sel        = grant[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_src    <= 1'b0;
            last_reg   <= 1'b1;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= result[sel];
            out_tag    <= tag[sel];
            out_src    <= sel;
            last_reg   <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
